// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, constants and FSM state type for the instruction cache
package icache_pkg;
    localparam int IndexBitsDef = 6;
    localparam int TagBitsDef = 24;
    localparam int PcLength = 32;
    localparam int DataLength = 32;
    localparam logic [31:0] Zero = '0;
    localparam logic True = 1'b1;
    localparam logic False = 1'b0;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side, ROB flush and fc-side signals of the instruction cache
interface icache_if;
    import icache_pkg::*;
    logic                  is_req_from_if;
    logic [PcLength-1:0]   addr_from_if;
    logic                  is_ready_to_if;
    logic                  is_valid_to_if;
    logic [DataLength-1:0] data_to_if;
    logic [PcLength-1:0]   addr_to_if;
    logic                  is_exception_from_rob;
    logic                  is_ready_from_fc;
    logic                  is_empty_to_fc;
    logic [PcLength-1:0]   addr_to_fc;
    logic                  is_commit_from_fc;
    logic                  is_instr_from_fc;
    logic [DataLength-1:0] data_from_fc;
    modport slave (
        input  is_req_from_if, addr_from_if, is_exception_from_rob,
        input  is_ready_from_fc, is_commit_from_fc, is_instr_from_fc, data_from_fc,
        output is_ready_to_if, is_valid_to_if, data_to_if, addr_to_if,
        output is_empty_to_fc, addr_to_fc
    );
    modport master (
        output is_req_from_if, addr_from_if, is_exception_from_rob,
        output is_ready_from_fc, is_commit_from_fc, is_instr_from_fc, data_from_fc,
        input  is_ready_to_if, is_valid_to_if, data_to_if, addr_to_if,
        input  is_empty_to_fc, addr_to_fc
    );
endinterface

// File: rtl/icache_array.sv
// icache_array: direct-mapped valid/tag/data storage, async read, sync write, sync clear-all
module icache_array
    import icache_pkg::*;
#(
    parameter int IndexBits = IndexBitsDef,
    parameter int TagBits = TagBitsDef
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IndexBits-1:0]  rd_idx,
    output logic                  rd_valid,
    output logic [TagBits-1:0]    rd_tag,
    output logic [DataLength-1:0] rd_data,
    input  logic                  we,
    input  logic [IndexBits-1:0]  wr_idx,
    input  logic [TagBits-1:0]    wr_tag,
    input  logic [DataLength-1:0] wr_data
);
    localparam int Lines = 1 << IndexBits;
    logic [Lines-1:0]      valid;
    logic [TagBits-1:0]    tag_mem [Lines];
    logic [DataLength-1:0] data_mem [Lines];
    assign rd_valid = valid[rd_idx];
    assign rd_tag = tag_mem[rd_idx];
    assign rd_data = data_mem[rd_idx];
    always_ff @(posedge clk) begin
        if (!rst)
            valid <= '0;
        else if (we)
            valid[wr_idx] <= True;
    end
    // Tag/data need no reset: a line is only read through its valid bit
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx] <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-line instruction cache between fetch and the fc memory fetcher
module icache
    import icache_pkg::*;
#(
    parameter int IndexBits = IndexBitsDef,
    parameter int TagBits = TagBitsDef
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   rdy,
    icache_if.slave bus
);
    state_t state, state_n;
    logic [PcLength-1:0]   lat_addr, addr_r, afc_r;
    logic [DataLength-1:0] data_r;
    logic                  valid_r, empty_r;
    logic                  rd_valid, hit, accept, fill, issue;
    logic [TagBits-1:0]    rd_tag;
    logic [DataLength-1:0] rd_data;
    icache_array #(.IndexBits(IndexBits), .TagBits(TagBits)) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (bus.addr_from_if[IndexBits+1:2]),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .we      (rst && rdy && fill),
        .wr_idx  (lat_addr[IndexBits+1:2]),
        .wr_tag  (lat_addr[IndexBits+TagBits+1:IndexBits+2]),
        .wr_data (bus.data_from_fc)
    );
    assign hit = rd_valid && rd_tag == bus.addr_from_if[IndexBits+TagBits+1:IndexBits+2];
    assign accept = state == IDLE && bus.is_req_from_if && !bus.is_exception_from_rob;
    assign fill = state == WAIT && bus.is_commit_from_fc && bus.is_instr_from_fc && !bus.is_exception_from_rob;
    assign issue = state == ISSUE && bus.is_ready_from_fc && !bus.is_exception_from_rob;
    // An exception always routes through FLUSH so a stale fc commit is swallowed
    always_comb begin
        state_n = state;
        state_n = bus.is_exception_from_rob ? FLUSH :
                  state == IDLE  ? (accept && !hit ? ISSUE : IDLE) :
                  state == ISSUE ? (issue ? WAIT : ISSUE) :
                  state == WAIT  ? (fill ? IDLE : WAIT) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            lat_addr <= Zero;
            valid_r <= False;
            data_r <= Zero;
            addr_r <= Zero;
            empty_r <= True;
            afc_r <= Zero;
        end else if (rdy) begin
            state <= state_n;
            valid_r <= (accept && hit) || fill;
            empty_r <= !issue;
            if (accept)
                lat_addr <= bus.addr_from_if;
            if (issue)
                afc_r <= lat_addr;
            if (accept && hit) begin
                data_r <= rd_data;
                addr_r <= bus.addr_from_if;
            end else if (fill) begin
                data_r <= bus.data_from_fc;
                addr_r <= lat_addr;
            end
        end
    end
    assign bus.is_ready_to_if = state == IDLE;
    assign bus.is_valid_to_if = valid_r;
    assign bus.data_to_if = data_r;
    assign bus.addr_to_if = addr_r;
    assign bus.is_empty_to_fc = empty_r;
    assign bus.addr_to_fc = afc_r;
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed stimulus with queue scoreboard for icache responses and fc requests
module tb_icache;
    logic clk = 0;
    logic rst = 0;
    logic rdy = 1;
    logic upd = 0;
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] fc_q[$];

    icache_if bus();
    icache dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus.slave));

    always #5 clk = ~clk;
    // Outputs are only fresh after an edge that actually updated the DUT
    always @(posedge clk) upd <= rst && rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (upd && bus.is_valid_to_if) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp: unexpected data=%h addr=%h", bus.data_to_if, bus.addr_to_if);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("resp_data", bus.data_to_if, e[63:32]);
                chk("resp_addr", bus.addr_to_if, e[31:0]);
            end
        end
        if (upd && !bus.is_empty_to_fc) begin
            if (fc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fc_req: unexpected addr=%h", bus.addr_to_fc);
            end else
                chk("fc_addr", bus.addr_to_fc, fc_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", bus.is_ready_to_if, 1);
        chk("rst_valid", bus.is_valid_to_if, 0);
        chk("rst_data", bus.data_to_if, 0);
        chk("rst_addr", bus.addr_to_if, 0);
        chk("rst_empty", bus.is_empty_to_fc, 1);
        chk("rst_afc", bus.addr_to_fc, 0);
    endtask

    task automatic wait_fc_req();
        for (int n = 0; n < 20 && bus.is_empty_to_fc; n++) tick();
        chk("fc_req_timeout", bus.is_empty_to_fc, 0);
    endtask

    task automatic commit(input logic [31:0] d, input logic instr);
        bus.is_commit_from_fc = 1;
        bus.is_instr_from_fc = instr;
        bus.data_from_fc = d;
        tick();
        bus.is_commit_from_fc = 0;
        bus.is_instr_from_fc = 0;
    endtask

    task automatic start_miss(input logic [31:0] a);
        fc_q.push_back(a);
        bus.is_req_from_if = 1;
        bus.addr_from_if = a;
        tick();
        bus.is_req_from_if = 0;
        wait_fc_req();
    endtask

    task automatic miss(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({d, a});
        start_miss(a);
        repeat (2) tick();
        commit(d, 1);
        chk("miss_valid", bus.is_valid_to_if, 1);
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({d, a});
        bus.is_req_from_if = 1;
        bus.addr_from_if = a;
        tick();
        bus.is_req_from_if = 0;
        chk("hit_valid", bus.is_valid_to_if, 1);
        tick();
    endtask

    initial begin
        bus.is_req_from_if = 0;
        bus.addr_from_if = 0;
        bus.is_exception_from_rob = 0;
        bus.is_ready_from_fc = 1;
        bus.is_commit_from_fc = 0;
        bus.is_instr_from_fc = 0;
        bus.data_from_fc = 0;
        repeat (2) tick();
        chk_reset_vals();
        rst = 1;
        // Cold miss, commit four cycles after the fc pulse
        exp_q.push_back({32'h0000_0013, 32'h0000_1000});
        start_miss(32'h0000_1000);
        repeat (3) tick();
        commit(32'h0000_0013, 1);
        chk("cold_valid", bus.is_valid_to_if, 1);
        // Back-to-back hits
        bus.is_req_from_if = 1;
        bus.addr_from_if = 32'h0000_1000;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({32'h0000_0013, 32'h0000_1000});
            tick();
            chk("stream_valid", bus.is_valid_to_if, 1);
        end
        bus.is_req_from_if = 0;
        tick();
        chk("stream_end", bus.is_valid_to_if, 0);
        // Conflict on index 0
        miss(32'h0000_1100, 32'hdead_beef);
        tick();
        miss(32'h0000_1000, 32'h0000_0013);
        tick();
        hit(32'h0000_1000, 32'h0000_0013);
        // Back-pressure, plus an ignored load commit
        bus.is_ready_from_fc = 0;
        fc_q.push_back(32'h0000_2004);
        exp_q.push_back({32'h1111_1111, 32'h0000_2004});
        bus.is_req_from_if = 1;
        bus.addr_from_if = 32'h0000_2004;
        tick();
        bus.is_req_from_if = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_empty", bus.is_empty_to_fc, 1);
        end
        bus.is_ready_from_fc = 1;
        tick();
        chk("bp_pulse", bus.is_empty_to_fc, 0);
        tick();
        chk("bp_once", bus.is_empty_to_fc, 1);
        commit(32'h0000_0bad, 0);
        chk("load_ignored_valid", bus.is_valid_to_if, 0);
        chk("load_ignored_ready", bus.is_ready_to_if, 0);
        commit(32'h1111_1111, 1);
        tick();
        hit(32'h0000_2004, 32'h1111_1111);
        // Exception during WAIT, late commit swallowed
        start_miss(32'h0000_3008);
        tick();
        bus.is_exception_from_rob = 1;
        tick();
        bus.is_exception_from_rob = 0;
        chk("flush_valid", bus.is_valid_to_if, 0);
        chk("flush_ready", bus.is_ready_to_if, 0);
        commit(32'h0000_0099, 1);
        chk("flush_ready_back", bus.is_ready_to_if, 1);
        chk("flush_no_resp", bus.is_valid_to_if, 0);
        miss(32'h0000_3008, 32'h7777_7777);
        tick();
        // Exception in ISSUE cancels the unsent request
        bus.is_ready_from_fc = 0;
        bus.is_req_from_if = 1;
        bus.addr_from_if = 32'h0000_5000;
        tick();
        bus.is_req_from_if = 0;
        bus.is_exception_from_rob = 1;
        tick();
        bus.is_exception_from_rob = 0;
        bus.is_ready_from_fc = 1;
        chk("issue_cancel_empty", bus.is_empty_to_fc, 1);
        tick();
        chk("issue_cancel_empty2", bus.is_empty_to_fc, 1);
        chk("issue_cancel_ready", bus.is_ready_to_if, 1);
        // Reset mid-miss clears lines
        start_miss(32'h0000_4000);
        tick();
        rst = 0;
        tick();
        chk_reset_vals();
        rst = 1;
        miss(32'h0000_1000, 32'h0000_0013);
        tick();
        // rdy low holds a pending hit pulse
        exp_q.push_back({32'h0000_0013, 32'h0000_1000});
        bus.is_req_from_if = 1;
        bus.addr_from_if = 32'h0000_1000;
        tick();
        bus.is_req_from_if = 0;
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", bus.is_valid_to_if, 1);
            chk("hold_data", bus.data_to_if, 32'h0000_0013);
        end
        rdy = 1;
        tick();
        chk("hold_release", bus.is_valid_to_if, 0);
        repeat (3) tick();
        chk("exp_q_drained", exp_q.size(), 0);
        chk("fc_q_drained", fc_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
